uart_fifo_param: RTL and testbench

//  Parametrised synchronous FIFO for the UART TX/RX data paths; successor to the fixed 8-bit FIFO.

---
 rtl/uart_fifo_pkg.sv | 35 +++
 rtl/uart_fifo_sdpram.sv | 46 ++++
 rtl/uart_fifo_param.sv | 130 +++++++++++++
 tb/tb_uart_fifo_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the parametrised UART FIFO.
// Contents:
//   FIFO_DEPTH_MAX            largest supported DEPTH
//   clog2()                   constant ceiling-log2 for elaboration checks
//   UART_FIFO_ASSERT_POW2     elaboration check: DEPTH is a power of 2
//   UART_FIFO_ASSERT_AW       elaboration check: AW == clog2(DEPTH)
`ifndef UART_FIFO_PKG_SV
`define UART_FIFO_PKG_SV

`define UART_FIFO_ASSERT_POW2(d) \
  if (((d) & ((d) - 1)) != 0) begin : g_depth_not_pow2 \
    $error("uart_fifo: DEPTH must be a power of 2"); \
  end

`define UART_FIFO_ASSERT_AW(d, aw) \
  if ((aw) != uart_fifo_pkg::clog2(d)) begin : g_aw_mismatch \
    $error("uart_fifo: AW must equal clog2(DEPTH)"); \
  end

`endif

package uart_fifo_pkg;

  localparam int unsigned FIFO_DEPTH_MAX = 1024;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_sdpram.sv
// Simple dual-port WIDTH x DEPTH storage array for the UART FIFO.
// Ports:
//   clk             write clock (and read clock when registered)
//   rst_n           async active-low reset of the registered read output
//   clr             synchronous clear of the registered read output
//   wr_en/wr_addr/din   write port
//   rd_en/rd_addr       read port
//   dout            read data: registered (FWFT=0) or combinational (FWFT=1)
module uart_fifo_sdpram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  if (FWFT != 0) begin : g_comb_rd
    logic unused_rd_ctl;
    assign unused_rd_ctl = ^{rst_n, clr, rd_en};
    assign dout = mem[rd_addr];
  end else begin : g_reg_rd
    // Read-before-write: a read of the address being written returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     dout <= '0;
      else if (clr)   dout <= '0;
      else if (rd_en) dout <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX data paths.
// Ports:
//   CLK, RESET        clock (rising edge), async active-low reset
//   WRB, DIN          active-low write strobe and write data
//   RDB, DOUT         active-low read strobe and read data
//   FLUSH, CLR_ERR    synchronous clear of contents / of sticky errors
//   THRESH, GEQTH     programmable level and COUNT >= THRESH flag
//   FULL, EMPTY, AFULL, AEMPTY, COUNT   fill status
//   OVERFLOW, UNDERFLOW                 sticky error flags
module uart_fifo_param
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 128,
  parameter int unsigned AW            = 7,
  parameter int unsigned AFULL_MARGIN  = 2,
  parameter int unsigned AEMPTY_MARGIN = 2,
  parameter int unsigned FWFT          = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WRB,
  input  logic             RDB,
  input  logic [WIDTH-1:0] DIN,
  input  logic             FLUSH,
  input  logic             CLR_ERR,
  input  logic [AW:0]      THRESH,
  output logic [WIDTH-1:0] DOUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic             GEQTH,
  output logic [AW:0]      COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  `UART_FIFO_ASSERT_POW2(DEPTH)
  `UART_FIFO_ASSERT_AW(DEPTH, AW)

  if (DEPTH < 4 || DEPTH > FIFO_DEPTH_MAX) begin : g_depth_range
    $error("uart_fifo: DEPTH out of range");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_width_range
    $error("uart_fifo: WIDTH out of range");
  end

  localparam logic [AW:0] DEPTH_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_MARGIN);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;
  logic          wr_en;
  logic          rd_en;
  logic          ovf_set;
  logic          unf_set;

  assign wr_ok   = ~WRB & (~FULL | ~RDB);
  assign rd_ok   = ~RDB & ~EMPTY;
  assign wr_en   = wr_ok & ~FLUSH;
  assign rd_en   = rd_ok & ~FLUSH;
  assign ovf_set = ~WRB & FULL & RDB;
  assign unf_set = ~RDB & EMPTY;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FLUSH beats a new error, which beats CLR_ERR.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (FLUSH) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (ovf_set)      OVERFLOW  <= 1'b1;
      else if (CLR_ERR) OVERFLOW  <= 1'b0;
      if (unf_set)      UNDERFLOW <= 1'b1;
      else if (CLR_ERR) UNDERFLOW <= 1'b0;
    end
  end

  assign COUNT  = count;
  assign FULL   = (count == DEPTH_LVL);
  assign EMPTY  = (count == '0);
  assign AFULL  = (count >= AFULL_LVL);
  assign AEMPTY = (count <= AEMPTY_LVL);
  assign GEQTH  = (count >= THRESH);

  uart_fifo_sdpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .FWFT  (FWFT)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (RESET),
    .clr     (FLUSH),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .din     (DIN),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .dout    (DOUT)
  );

endmodule

// File: tb/tb_uart_fifo_param.sv
module tb_uart_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] thresh = 5'd8;

  logic       wrb0 = 1'b1, rdb0 = 1'b1, flush0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = '0;
  logic [7:0] dout0;
  logic       full0, empty0, afull0, aempty0, geqth0, ovf0, unf0;
  logic [4:0] count0;

  logic       wrb1 = 1'b1, rdb1 = 1'b1, flush1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = '0;
  logic [7:0] dout1;
  logic       full1, empty1, afull1, aempty1, geqth1, ovf1, unf1;
  logic [4:0] count1;

  int n_vec = 0;
  int n_fail = 0;

  // scoreboard state
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic       rd_fire = 1'b0, fl_fire = 1'b0;

  always #5 clk = ~clk;

  uart_fifo_param #(.WIDTH(8), .DEPTH(16), .AW(4), .AFULL_MARGIN(2),
                    .AEMPTY_MARGIN(2), .FWFT(0)) u0 (
    .CLK(clk), .RESET(rst_n), .WRB(wrb0), .RDB(rdb0), .DIN(din0),
    .FLUSH(flush0), .CLR_ERR(clr0), .THRESH(thresh), .DOUT(dout0),
    .FULL(full0), .EMPTY(empty0), .AFULL(afull0), .AEMPTY(aempty0),
    .GEQTH(geqth0), .COUNT(count0), .OVERFLOW(ovf0), .UNDERFLOW(unf0));

  uart_fifo_param #(.WIDTH(8), .DEPTH(16), .AW(4), .AFULL_MARGIN(2),
                    .AEMPTY_MARGIN(2), .FWFT(1)) u1 (
    .CLK(clk), .RESET(rst_n), .WRB(wrb1), .RDB(rdb1), .DIN(din1),
    .FLUSH(flush1), .CLR_ERR(clr1), .THRESH(thresh), .DOUT(dout1),
    .FULL(full1), .EMPTY(empty1), .AFULL(afull1), .AEMPTY(aempty1),
    .GEQTH(geqth1), .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(unf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus on the registered-read FIFO; the model predicts
  // flags and queues the word a read will present.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic fl, input logic ce);
    bit full, empty, wok, rok;
    @(negedge clk);
    wrb0 = w; rdb0 = r; din0 = d; flush0 = fl; clr0 = ce;
    full  = (m_cnt == DEPTH);
    empty = (m_cnt == 0);
    wok = !w && (!full || !r) && !fl;
    rok = !r && !empty && !fl;
    rd_fire = rok;
    fl_fire = fl;
    if (fl) begin
      m_q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (rok) exp_q.push_back(m_q.pop_front());
      if (wok) m_q.push_back(d);
      m_cnt = m_cnt + int'(wok) - int'(rok);
      if (!w && full && r) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (!r && empty)     m_unf = 1'b1; else if (ce) m_unf = 1'b0;
    end
    @(posedge clk); #1;
    chk("count",     32'(count0),  32'(m_cnt));
    chk("full",      32'(full0),   32'(m_cnt == 16));
    chk("empty",     32'(empty0),  32'(m_cnt == 0));
    chk("afull",     32'(afull0),  32'(m_cnt >= 14));
    chk("aempty",    32'(aempty0), 32'(m_cnt <= 2));
    chk("geqth",     32'(geqth0),  32'(m_cnt >= 8));
    chk("overflow",  32'(ovf0),    32'(m_ovf));
    chk("underflow", 32'(unf0),    32'(m_unf));
    rd_fire = 1'b0; fl_fire = 1'b0;
    wrb0 = 1'b1; rdb0 = 1'b1; flush0 = 1'b0; clr0 = 1'b0;
  endtask

  // One clock on the FWFT FIFO; checks are directed at the call site.
  task automatic c1(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wrb1 = w; rdb1 = r; din1 = d;
    @(posedge clk); #1;
    wrb1 = 1'b1; rdb1 = 1'b1;
  endtask

  // Monitor: whenever a read was accepted last edge, DOUT must present the
  // next scoreboard word; otherwise DOUT must hold (or be 0 after reset/flush).
  initial begin : monitor
    logic [7:0] exp_dout;
    logic rf, ff, rs;
    exp_dout = '0;
    forever begin
      @(posedge clk);
      rf = rd_fire; ff = fl_fire; rs = rst_n;
      #1;
      if (!rs) exp_dout = '0;
      else if (ff) exp_dout = '0;
      else if (rf) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL sb_underrun: got read with empty scoreboard at %0t", $time);
        end else exp_dout = exp_q.pop_front();
      end
      chk("dout", 32'(dout0), 32'(exp_dout));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state, including GEQTH=1 when THRESH=0
    thresh = 5'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count",  32'(count0),  32'd0);
    chk("rst_empty",  32'(empty0),  32'd1);
    chk("rst_aempty", 32'(aempty0), 32'd1);
    chk("rst_full",   32'(full0),   32'd0);
    chk("rst_afull",  32'(afull0),  32'd0);
    chk("rst_geq_t0", 32'(geqth0),  32'd1);
    chk("rst_ovf",    32'(ovf0),    32'd0);
    chk("rst_unf",    32'(unf0),    32'd0);
    chk("rst_dout",   32'(dout0),   32'd0);
    thresh = 5'd8;
    #1 chk("rst_geq_t8", 32'(geqth0), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 7)  chk("t1_geq_at7",   32'(geqth0), 32'd0);
      if (i == 8)  chk("t1_geq_at8",   32'(geqth0), 32'd1);
      if (i == 13) chk("t1_afull_13",  32'(afull0), 32'd0);
      if (i == 14) chk("t1_afull_14",  32'(afull0), 32'd1);
      if (i == 15) chk("t1_full_15",   32'(full0),  32'd0);
    end
    chk("t1_count16", 32'(count0), 32'd16);
    chk("t1_full",    32'(full0),  32'd1);

    // 2: write while full, then drain in order
    cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t2_ovf",     32'(ovf0),   32'd1);
    chk("t2_count",   32'(count0), 32'd16);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_last",    32'(dout0),  32'h10);
    chk("t2_empty",   32'(empty0), 32'd1);

    // 3: read while empty; then clear; set-vs-clear coincidence
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_unf",     32'(unf0),   32'd1);
    chk("t3_hold",    32'(dout0),  32'h10);
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("t3_clr_ovf", 32'(ovf0),   32'd0);
    chk("t3_clr_unf", 32'(unf0),   32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_set_wins", 32'(unf0),  32'd1);
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

    // simultaneous read+write while empty: write taken, read flagged
    cyc(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    chk("t3_rw_empty_cnt", 32'(count0), 32'd1);
    chk("t3_rw_empty_unf", 32'(unf0),   32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_rw_empty_dat", 32'(dout0),  32'h5A);

    // 4: full with continuous read+write across pointer wrap
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("t4_count",   32'(count0), 32'd16);
    chk("t4_no_ovf",  32'(ovf0),   32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_last",    32'(dout0),  32'hA7);

    // 5: FWFT instance
    c1(1'b0, 1'b1, 8'hA5);
    chk("t5_dout_a5",  32'(dout1),  32'hA5);
    chk("t5_cnt1",     32'(count1), 32'd1);
    chk("t5_nempty",   32'(empty1), 32'd0);
    c1(1'b1, 1'b0, 8'h00);
    chk("t5_empty",    32'(empty1), 32'd1);
    c1(1'b0, 1'b1, 8'h11);
    c1(1'b0, 1'b1, 8'h22);
    chk("t5_head11",   32'(dout1),  32'h11);
    c1(1'b1, 1'b0, 8'h00);
    chk("t5_head22",   32'(dout1),  32'h22);
    c1(1'b0, 1'b0, 8'h33);
    chk("t5_rw_cnt",   32'(count1), 32'd1);
    chk("t5_head33",   32'(dout1),  32'h33);
    c1(1'b1, 1'b0, 8'h00);
    chk("t5_empty2",   32'(empty1), 32'd1);
    chk("t5_no_unf",   32'(unf1),   32'd0);

    // 6: flush with WRB low
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_pre_dout", 32'(dout0),  32'h51);
    cyc(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("t6_fl_count", 32'(count0), 32'd0);
    chk("t6_fl_empty", 32'(empty0), 32'd1);
    chk("t6_fl_dout",  32'(dout0),  32'd0);

    // async reset mid-burst
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h64, 1'b0, 1'b0);
    chk("t6_pre_rst", 32'(dout0), 32'h61);
    @(negedge clk);
    wrb0 = 1'b0; din0 = 8'h65;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count",  32'(count0),  32'd0);
    chk("t6_rst_empty",  32'(empty0),  32'd1);
    chk("t6_rst_aempty", 32'(aempty0), 32'd1);
    chk("t6_rst_full",   32'(full0),   32'd0);
    chk("t6_rst_dout",   32'(dout0),   32'd0);
    m_q.delete(); exp_q.delete();
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_hold",   32'(count0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; wrb0 = 1'b1;
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_after_rst", 32'(dout0), 32'h77);

    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
